// File: rtl/controlunit_pkg.sv
// Shared constants and FSM encoding for the control sequencer and its helpers.
package controlunit_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned STEP_W     = 2;
  localparam int unsigned STATUS_W   = 5;
  localparam int unsigned STEP_CNT_W = 3;
  localparam int unsigned PERF_W     = 32;

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } seq_fsm_e;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: +1 per enabled cycle, wraps to zero after all-ones.
module perf_counter
  import controlunit_pkg::*;
(
  input  logic              enable,
  input  logic              clock,
  input  logic              reset,
  output logic [PERF_W-1:0] count
);

  logic [PERF_W-1:0] r_count;

  // Count enabled cycles; synchronous reset clears.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + PERF_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: latches an instruction, walks decoder-chosen steps,
// retires on NS==0 or when the step budget MAX_STEPS is exhausted.
// Optional performance counters are built when CONTROL_SEQUENCER_PERF_EN is defined.
module control_sequencer
  import controlunit_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 4
)
(
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr_data,
  output logic                instr_ready,
  output logic [INSTR_W-1:0]  I,
  output logic [STEP_W-1:0]   state,
  output logic [STATUS_W-1:0] status,
  input  logic [STEP_W-1:0]   NS,
  input  logic                status_load,
  input  logic [STATUS_W-1:0] alu_status,
  output logic                exec,
  output logic                retire
`ifdef CONTROL_SEQUENCER_PERF_EN
  ,
  output logic [PERF_W-1:0]   retired_count,
  output logic [PERF_W-1:0]   stall_count
`endif
);

  seq_fsm_e              r_fsm,      w_fsm_nxt;
  logic [INSTR_W-1:0]    r_instr,    w_instr_nxt;
  logic [STEP_W-1:0]     r_state,    w_state_nxt;
  logic [STATUS_W-1:0]   r_status,   w_status_nxt;
  logic [STEP_CNT_W-1:0] r_step_cnt, w_step_cnt_nxt;
  logic                  w_instr_ready;
  logic                  w_exec;
  logic                  w_retire;
  logic                  w_budget_done;

  // Step counter holds the 1-based index of the current EXECUTE cycle.
  assign w_budget_done = (r_step_cnt == STEP_CNT_W'(MAX_STEPS));

  // State register for FSM, instruction, step and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm      <= FETCH;
      r_instr    <= '0;
      r_state    <= '0;
      r_status   <= '0;
      r_step_cnt <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_instr    <= w_instr_nxt;
      r_state    <= w_state_nxt;
      r_status   <= w_status_nxt;
      r_step_cnt <= w_step_cnt_nxt;
    end
  end

  // Next-state and handshake/control outputs.
  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_instr_nxt    = r_instr;
    w_state_nxt    = r_state;
    w_step_cnt_nxt = r_step_cnt;
    w_instr_ready  = 1'b0;
    w_exec         = 1'b0;
    w_retire       = 1'b0;
    case (r_fsm)
      FETCH: begin
        w_instr_ready = 1'b1;
        if (instr_valid) begin
          w_instr_nxt    = instr_data;
          w_state_nxt    = '0;
          w_step_cnt_nxt = STEP_CNT_W'(1);
          w_fsm_nxt      = EXECUTE;
        end
      end
      EXECUTE: begin
        w_exec = 1'b1;
        if ((NS == '0) || w_budget_done) begin
          w_retire       = 1'b1;
          w_state_nxt    = '0;
          w_step_cnt_nxt = '0;
          w_fsm_nxt      = FETCH;
        end else begin
          w_state_nxt    = NS;
          w_step_cnt_nxt = r_step_cnt + STEP_CNT_W'(1);
        end
      end
    endcase
  end

  // Status flags capture ALU flags only on an executing cycle that asks for it.
  always_comb begin
    w_status_nxt = r_status;
    if (w_exec && status_load) begin
      w_status_nxt = alu_status;
    end
  end

  assign instr_ready = w_instr_ready;
  assign exec        = w_exec;
  assign retire      = w_retire;
  assign I           = r_instr;
  assign state       = r_state;
  assign status      = r_status;

`ifdef CONTROL_SEQUENCER_PERF_EN
  logic w_stall;

  assign w_stall = w_instr_ready & ~instr_valid;

  perf_counter u_retired_cnt (
    .enable (w_retire),
    .clock  (clock),
    .reset  (reset),
    .count  (retired_count)
  );

  perf_counter u_stall_cnt (
    .enable (w_stall),
    .clock  (clock),
    .reset  (reset),
    .count  (stall_count)
  );
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver predicts each EXECUTE cycle
// from the step rules and queues it; a negedge monitor pops and compares.
module tb_control_sequencer;

  localparam int unsigned MAX = 4;

  typedef logic [1:0] ns_t  [4];
  typedef logic       sl_t  [4];
  typedef logic [4:0] alu_t [4];

  typedef struct {
    logic [31:0] i;
    logic [1:0]  st;
    logic [4:0]  sts;
    logic        ret;
  } exp_t;

  logic        clock       = 1'b0;
  logic        reset       = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr_data  = '0;
  logic [1:0]  NS          = '0;
  logic        status_load = 1'b0;
  logic [4:0]  alu_status  = '0;
  logic        instr_ready;
  logic [31:0] I;
  logic [1:0]  state;
  logic [4:0]  status;
  logic        exec;
  logic        retire;
`ifdef CONTROL_SEQUENCER_PERF_EN
  logic [31:0] retired_count;
  logic [31:0] stall_count;
`endif

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [4:0]  status_m = '0;
  int unsigned retired_m = 0;
  int unsigned stall_m = 0;

  control_sequencer #(.MAX_STEPS(MAX)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .I           (I),
    .state       (state),
    .status      (status),
    .NS          (NS),
    .status_load (status_load),
    .alu_status  (alu_status),
    .exec        (exec),
    .retire      (retire)
`ifdef CONTROL_SEQUENCER_PERF_EN
    ,
    .retired_count (retired_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every executing cycle must match the oldest queued prediction.
  always @(negedge clock) begin
    if (!reset) begin
      if (exec) begin
        if (q.size() == 0) begin
          chk("exec_unexpected", 32'(exec), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("exec_I", I, e.i);
          chk("exec_state", 32'(state), 32'(e.st));
          chk("exec_status", 32'(status), 32'(e.sts));
          chk("exec_retire", 32'(retire), 32'(e.ret));
          chk("exec_ready", 32'(instr_ready), 32'd0);
        end
      end else begin
        chk("fetch_retire", 32'(retire), 32'd0);
        chk("fetch_ready", 32'(instr_ready), 32'd1);
        chk("fetch_state", 32'(state), 32'd0);
      end
    end
  end

  // Issue one instruction after n_idle stall cycles; predict each step from the rules.
  task automatic run_instr(input logic [31:0] ins, input int n_idle,
                           input ns_t ns, input sl_t sl, input alu_t alu);
    int         n;
    logic [1:0] prev;
    exp_t       e;
    for (int j = 0; j < n_idle; j++) begin
      instr_valid = 1'b0;
      instr_data  = $urandom;
      NS          = 2'($urandom);
      status_load = 1'($urandom);
      alu_status  = 5'($urandom);
      stall_m++;
      tick();
    end
    instr_valid = 1'b1;
    instr_data  = ins;
    NS          = 2'($urandom);
    status_load = 1'($urandom);
    alu_status  = 5'($urandom);
    tick();
    n = MAX;
    for (int k = MAX - 1; k >= 0; k--) begin
      if (ns[k] == 2'd0) n = k + 1;
    end
    prev = 2'd0;
    for (int k = 0; k < n; k++) begin
      instr_valid = 1'($urandom);
      instr_data  = $urandom;
      NS          = ns[k];
      status_load = sl[k];
      alu_status  = alu[k];
      e.i   = ins;
      e.st  = prev;
      e.sts = status_m;
      e.ret = (k == n - 1);
      q.push_back(e);
      if (sl[k]) status_m = alu[k];
      prev = ns[k];
      tick();
    end
    retired_m++;
    instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ns_t  ns_v;
    sl_t  sl_v;
    alu_t alu_v;
    exp_t e;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_I", I, 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_exec", 32'(exec), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);

    // Single-step instruction
    ns_v = '{2'd0, 2'd0, 2'd0, 2'd0};
    sl_v = '{1'b0, 1'b0, 1'b0, 1'b0};
    alu_v = '{5'd0, 5'd0, 5'd0, 5'd0};
    run_instr(32'h91000421, 0, ns_v, sl_v, alu_v);
    #1;
    chk("single_ready_after", 32'(instr_ready), 32'd1);
    chk("single_exec_after", 32'(exec), 32'd0);
    chk("single_I_held", I, 32'h91000421);

    // Multi-step 1,2,0
    ns_v = '{2'd1, 2'd2, 2'd0, 2'd0};
    run_instr(32'h12345678, 0, ns_v, sl_v, alu_v);

    // Runaway guard
    ns_v = '{2'd1, 2'd1, 2'd1, 2'd1};
    run_instr(32'hDEAD0001, 1, ns_v, sl_v, alu_v);
    #1;
    chk("runaway_fetch", 32'(instr_ready), 32'd1);
    ns_v = '{2'd3, 2'd2, 2'd3, 2'd1};
    run_instr(32'hDEAD0002, 0, ns_v, sl_v, alu_v);

    // Status load on retire cycle, then hold
    ns_v = '{2'd0, 2'd0, 2'd0, 2'd0};
    sl_v = '{1'b1, 1'b0, 1'b0, 1'b0};
    alu_v = '{5'b10101, 5'd0, 5'd0, 5'd0};
    run_instr(32'h0000AAAA, 0, ns_v, sl_v, alu_v);
    #1;
    chk("status_loaded", 32'(status), 32'(5'b10101));
    sl_v = '{1'b0, 1'b0, 1'b0, 1'b0};
    alu_v = '{5'b01010, 5'd0, 5'd0, 5'd0};
    run_instr(32'h0000BBBB, 0, ns_v, sl_v, alu_v);
    #1;
    chk("status_held", 32'(status), 32'(5'b10101));

    // Reset in second EXECUTE cycle abandons the instruction
    instr_valid = 1'b1;
    instr_data  = 32'hCAFE0001;
    status_load = 1'b0;
    tick();
    instr_valid = 1'b0;
    NS          = 2'd1;
    e.i = 32'hCAFE0001; e.st = 2'd0; e.sts = status_m; e.ret = 1'b0;
    q.push_back(e);
    tick();
    NS          = 2'd2;
    status_load = 1'b1;
    alu_status  = 5'b11111;
    reset       = 1'b1;
    #1;
    chk("rst_exec_no_retire", 32'(retire), 32'd0);
    tick();
    reset       = 1'b0;
    status_load = 1'b0;
    NS          = 2'd0;
    #1;
    status_m  = '0;
    retired_m = 0;
    stall_m   = 0;
    chk("rst2_I", I, 32'h0);
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_status", 32'(status), 32'd0);
    chk("rst2_exec", 32'(exec), 32'd0);
    chk("rst2_retire", 32'(retire), 32'd0);
    chk("rst2_ready", 32'(instr_ready), 32'd1);

    // Three single-step instructions with two idle fetch cycles
    ns_v = '{2'd0, 2'd0, 2'd0, 2'd0};
    run_instr(32'h00000001, 1, ns_v, sl_v, alu_v);
    run_instr(32'h00000002, 1, ns_v, sl_v, alu_v);
    run_instr(32'h00000003, 0, ns_v, sl_v, alu_v);
`ifdef CONTROL_SEQUENCER_PERF_EN
    #1;
    chk("perf_retired3", retired_count, 32'd3);
    chk("perf_stall2", stall_count, 32'd2);
`endif

    // Randomized instructions
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < 4; k++) begin
        ns_v[k]  = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        sl_v[k]  = 1'($urandom);
        alu_v[k] = 5'($urandom);
      end
      run_instr($urandom, int'($urandom_range(0, 2)), ns_v, sl_v, alu_v);
    end
    #1;
    chk("final_status", 32'(status), 32'(status_m));
    chk("queue_drained", 32'(q.size()), 32'd0);
`ifdef CONTROL_SEQUENCER_PERF_EN
    chk("perf_retired", retired_count, retired_m);
    chk("perf_stall", stall_count, stall_m);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
